// File: rtl/div_pkg.sv
// Shared widths, constants and state encoding for the iterative MIPS divider.
package div_pkg;

    localparam int XLEN       = 32;
    localparam int DIV_CYCLES = XLEN;
    localparam int CNT_W      = $clog2(DIV_CYCLES) + 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);
    localparam logic [XLEN-1:0]  DIV0_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Two's-complement negate when n is set; -(0x80000000) wraps back to itself.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;

    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {2'b00, dvs_i};
    // Top bit of the widened difference is the borrow: set means divisor did not fit.
    assign q_o     = ~trial[XLEN+1];
    assign rem_o   = q_o ? trial[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/div_iterative.sv
// Multi-cycle DIV/DIVU unit: restoring division on magnitudes, then sign fix-up.
// Optional macro DIV_EARLY_OUT_EN resolves b==0 and |a|<|b| directly from IDLE.
module div_iterative
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              sign,
    input  logic              start,
    input  logic              cancel,
    output logic [2*XLEN-1:0] result,
    output logic              ready,
    output logic              busy
);

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   araw_q, araw_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              bzero_q, bzero_d;
    logic [2*XLEN-1:0] result_q, result_d;
    logic              ready_q, ready_d;

    logic [XLEN-1:0]   a_mag, b_mag;
    logic              b_zero;
    logic [XLEN:0]     step_rem;
    logic              step_q;
    logic [XLEN-1:0]   q_fin, r_fin;

    assign a_mag  = cond_neg(a, sign & a[XLEN-1]);
    assign b_mag  = cond_neg(b, sign & b[XLEN-1]);
    assign b_zero = (b == '0);

    div_step u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[XLEN-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    assign q_fin = {quo_q[XLEN-2:0], step_q};
    assign r_fin = step_rem[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        araw_d   = araw_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        bzero_d  = bzero_q;
        result_d = result_q;
        ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    araw_d  = a;
                    qneg_d  = sign & (a[XLEN-1] ^ b[XLEN-1]);
                    rneg_d  = sign & a[XLEN-1];
                    bzero_d = b_zero;
                    state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
                    // Quotient is all-ones or zero and remainder is the raw dividend.
                    if (b_zero || (a_mag < b_mag)) begin
                        result_d = {a, b_zero ? DIV0_QUO : {XLEN{1'b0}}};
                        ready_d  = 1'b1;
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                    rem_d = step_rem;
                    quo_d = q_fin;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        if (bzero_q)
                            result_d = {araw_q, DIV0_QUO};
                        else
                            result_d = {cond_neg(r_fin, rneg_q), cond_neg(q_fin, qneg_q)};
                        ready_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            araw_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            araw_q   <= araw_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            bzero_q  <= bzero_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign busy   = (state_q == CALC);

endmodule
